seven_seg_scan: RTL
===================

# seven_seg_scan

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It takes the four 4-bit characters produced by the character memory (char3..char0), hex-decodes them, and scans the digits one at a time with active-low anode and segment outputs. It also emits a once-per-frame tick that upstream logic uses to advance addresses safely between frames.

## Interface
- CLK_DIV, 50000: clock cycles per digit slot; must be ≥ 4.
- DEAD_CYCLES, 500: blanked cycles at the start of each slot; must be < CLK_DIV. Used only with SCAN_DEADTIME_EN.
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  scan enable; low blanks the display and parks the scanner
- char3, char2, char1, char0  in  4 each  hex characters; char3 is the leftmost digit
- an  out  4  anode selects, active-low; an[3] is the leftmost digit
- seg  out  7  segments, active-low; seg[6]=a … seg[0]=g
- frame_tick  out  1  one-cycle pulse when the digit-0 slot ends
- digit_idx  out  2  index of the slot in progress (3..0)

## Operation
- States:
  - IDLE: enable low.
  - DEAD: anodes off, only with SCAN_DEADTIME_EN.
  - ON: one anode driven.
- Slot counter cnt runs 0..CLK_DIV-1. Digit index idx steps 3→2→1→0→3, advancing when cnt==CLK_DIV-1; cnt then wraps to 0.
- Character latch: at cnt==0 of each slot, char[idx] is captured into a 4-bit holding register. Input changes mid-slot have no effect until the next slot.
- Decode is standard hex:
  - 0→7'b0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100
  - 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100
  - A→0001000, b→1100000, C→0110001, d→1000010, E→0110000, F→0111000
- ON: an has the single bit idx low and seg shows the decoded latched character.
- DEAD and IDLE: an=4'b1111, seg=7'b1111111.
- frame_tick is high in the cycle in which idx==0 and cnt==CLK_DIV-1.
- Transitions:
  - IDLE→(DEAD or ON) when enable=1, starting a digit-3 slot with cnt=0.
  - DEAD→ON when cnt==DEAD_CYCLES-1.
  - ON→(DEAD or ON) at the slot end.
  - Any state→IDLE when enable=0.
- Entering IDLE clears cnt and sets idx=3. Re-enabling always starts from digit 3.

## Timing
- Reset values: an=4'b1111, seg=7'b1111111, frame_tick=0, digit_idx=2'd3, state IDLE, cnt=0, holding register=0.
- an, seg and frame_tick are registered. They reflect the state/cnt/idx of the previous cycle, giving one cycle of latency.
- digit_idx is the live idx register.
- After enable rises, the first cycle with an≠4'b1111 is:
  - cycle 2 without the macro
  - cycle DEAD_CYCLES+2 with it
- Full frame period is exactly 4·CLK_DIV cycles, and frame_tick pulses once per frame.
- Simultaneous enable fall and slot end: IDLE wins, frame_tick is not asserted, and idx goes to 3.
- Reset asserted mid-slot forces the reset values immediately, without waiting for clk.

## Configuration
- SCAN_DEADTIME_EN defined: each slot begins with DEAD_CYCLES of all-off anodes, then ON for CLK_DIV-DEAD_CYCLES cycles. This suppresses ghosting.
- SCAN_DEADTIME_EN undefined: there is no DEAD state and ON covers the whole slot. DEAD_CYCLES is ignored.

## Structure
- Shared package seven_seg_pkg holds:
  - the 16-entry hex segment constant table
  - the ANODES_OFF and SEG_BLANK constants
  - the scan-state typedef {IDLE, DEAD, ON}
- Sub-module hex_to_seg: combinational 4-bit to 7-bit decode from the package table. It is shared with other display paths.
- Top contains the counter, the idx register, the FSM, the holding register and the output registers.

## Test plan
- Reset held with enable=1 → an=4'b1111, seg=7'b1111111, digit_idx=3. After release, with no macro and CLK_DIV=8: an=4'b0111 from cycle 2.
- char3..0=A,5,C,8, CLK_DIV=8, no macro → an follows 0111,1011,1101,1110 for 8 cycles each, with seg=0001000, 0100100, 0110001, 0000000. frame_tick is high once every 32 cycles.
- SCAN_DEADTIME_EN, CLK_DIV=8, DEAD_CYCLES=2 → each slot shows 2 cycles of an=1111 then 6 cycles of the selected digit. Frame period is still 32.
- char1 changes from 1 to F at cnt=3 of the digit-1 slot → seg stays 1001111 for that slot. F (0111000) appears in the next frame.
- enable dropped at cnt=5 of the digit-2 slot → next cycle an=1111 and digit_idx=3. On re-enable, the scan restarts at digit 3 with no frame_tick.
- Async reset asserted between clock edges during ON → an and seg go all-ones before the next clk edge.

Source files
------------

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Brief    : Shared constants and scan-state type for the seven-segment path.
// Revision : 1.0
// ============================================================================
package seven_seg_pkg;

    localparam logic [3:0] ANODES_OFF = 4'b1111;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;

    // Active-low segments, seg[6]=a ... seg[0]=g, indexed by hex value.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg
// Brief    : Combinational 4-bit hex to active-low 7-segment decode.
// Revision : 1.0
// ============================================================================
module hex_to_seg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    import seven_seg_pkg::*;

    assign seg = HEX_SEG[digit];

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan
// Brief    : 4-digit common-anode scan driver with hex decode and frame tick.
//            Define SCAN_DEADTIME_EN to blank the first DEAD_CYCLES of a slot.
// Revision : 1.0
// ============================================================================
module seven_seg_scan #(
    parameter int unsigned CLK_DIV     = 50000,
    parameter int unsigned DEAD_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] char3,
    input  logic [3:0] char2,
    input  logic [3:0] char1,
    input  logic [3:0] char0,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_tick,
    output logic [1:0] digit_idx
);
    import seven_seg_pkg::*;

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

`ifdef SCAN_DEADTIME_EN
    localparam bit          USE_DEAD   = 1'b1;
    localparam scan_state_t SLOT_START = DEAD;
`else
    localparam bit          USE_DEAD   = 1'b0;
    localparam scan_state_t SLOT_START = ON;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(USE_DEAD ? DEAD_CYCLES - 1 : 0);

    scan_state_t      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       idx, idx_nx;
    logic [3:0]       hold;
    logic [3:0]       sel_char;
    logic [3:0]       cur_char;
    logic [6:0]       dec_seg;
    logic             slot_end;
    logic             showing;

    always_comb begin
        sel_char = char3;
        case (idx)
            2'd3:    sel_char = char3;
            2'd2:    sel_char = char2;
            2'd1:    sel_char = char1;
            default: sel_char = char0;
        endcase
    end

    // The slot's first cycle feeds the fresh character straight through so
    // the display shows it without waiting a cycle for the holding register.
    assign cur_char = (cnt == '0) ? sel_char : hold;

    hex_to_seg u_hex_to_seg (
        .digit (cur_char),
        .seg   (dec_seg)
    );

    assign slot_end  = (cnt == CNT_LAST);
    assign showing   = enable && (state == ON);
    assign digit_idx = idx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = SLOT_START;
                    cnt_nx   = '0;
                    idx_nx   = 2'd3;
                end
            end
            DEAD: begin
                if (cnt == DEAD_LAST) begin
                    state_nx = ON;
                end
                cnt_nx = cnt + 1'b1;
            end
            ON: begin
                if (slot_end) begin
                    state_nx = SLOT_START;
                    cnt_nx   = '0;
                    idx_nx   = idx - 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Disable overrides everything, including a coincident slot end.
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= 2'd3;
            hold  <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            hold  <= cur_char;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= ANODES_OFF;
            seg        <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            an         <= showing ? ~(4'b0001 << idx) : ANODES_OFF;
            seg        <= showing ? dec_seg : SEG_BLANK;
            frame_tick <= showing && (idx == 2'd0) && slot_end;
        end
    end

endmodule
`default_nettype wire
